proc_control: RTL and testbench
===============================

Name: proc_control

Overview:
- Multi-cycle control FSM for the 16-bit, 8-register processor. R7 is the PC.
- Sequences fetch and execute by driving register load/drive strobes, ALU, memory-address and write-data controls, and the PC increment/load controls.
- Sits beside the datapath; IR contents and the G-nonzero flag are fed back to it.

Parameters:
- NREG, 8: register count; Rin/Rout width.
- PC_IDX, 7: index of the PC register.
- IR_W, 9: instruction width, format III XXX YYY (opcode, X, Y).

Ports:
- Clock  in  1  rising-edge clock
- Resetn  in  1  async active-low reset
- Run  in  1  permits fetch of next instruction
- IR  in  IR_W  current instruction register contents
- Gnz  in  1  G register nonzero (mvnz condition)
- Rin  out  NREG  one-hot register load enables
- Rout  out  NREG  one-hot register bus drive
- Gout  out  1  G drives bus
- DINout  out  1  memory data drives bus
- IRin  out  1  IR loads from memory data
- Ain  out  1  A register load
- Gin  out  1  G register load
- alu_op  out  2  00 add, 01 sub, 10 and
- ADDRin  out  1  address register load from bus
- DOUTin  out  1  write-data register load from bus
- W_D  out  1  memory write enable
- incr_pc  out  1  PC increment
- Done  out  1  one-cycle pulse in the last step of each instruction

Behaviour:
- Reset and state encoding:
  - Resetn=0, asynchronous: state forced to T0.
  - All outputs are decoded from state and must read 0 while in reset, including W_D.
  - Reset mid-instruction abandons it. The next fetch starts at T0 once Resetn=1.
- Output timing: all outputs are combinational from (state, IR, Gnz, Run). No output register.
- States: T0, T1, T2, E1, E2, E3.
  - T0: if Run=1, Rout[PC_IDX], ADDRin, go T1; else all outputs 0, stay T0.
  - T1: incr_pc (memory read latency slot), go T2.
  - T2: IRin, go E1.
  - E-steps: per opcode below. After the Done step, go T0.
- Run: sampled only in T0. Deasserting Run mid-instruction does not stall it.
- Opcodes, E-steps:
  - 000 mv: E1 Rout=Y, Rin=X, Done.
  - 001 mvi: E1 Rout[PC], ADDRin. E2 incr_pc. E3 DINout, Rin=X, Done.
  - 010 add, 011 sub, 111 and: E1 Rout=X, Ain. E2 Rout=Y, Gin, alu_op=00/01/10. E3 Gout, Rin=X, Done.
    - alu_op is 00 in every step except add/sub/and E2.
  - 100 ld: E1 Rout=Y, ADDRin. E2 wait (no strobes). E3 DINout, Rin=X, Done.
  - 101 st: E1 Rout=Y, ADDRin. E2 Rout=X, DOUTin, W_D, Done.
  - 110 mvnz: E1 if Gnz: Rout=Y, Rin=X. Done regardless.
- Cycle counts: mv/mvnz 4; st 5; mvi/add/sub/and/ld 6.
- Invariants:
  - At most one of Rout bits, Gout, DINout asserted in any cycle.
  - Rin at most one-hot.
  - incr_pc and Rin[PC_IDX] never asserted in the same cycle (PC load has priority in the PC register regardless).
- X=PC_IDX writes are jumps. The next T0 fetches from the written value.

Decomposition:
- Shared package proc_pkg:
  - opcode localparams (OP_MV..OP_AND)
  - state encoding
  - alu_op codes
  - NREG/PC_IDX defaults
- Sub-module dec3to8: 3-bit to 8-bit one-hot decoder, instanced for X and Y fields.

Test Plan:
1. Resetn=0 asserted during add E2 -> all outputs 0 immediately; Resetn=1 with Run=1 -> next cycle Rout=8'h80, ADDRin=1.
2. Run=0 after reset for 5 cycles -> all outputs 0, state stays T0. Run=1 -> fetch begins same cycle.
3. mv R2,R5 (IR=000_010_101), Run=1 -> cycle 0 Rout=8'h80+ADDRin; 1 incr_pc; 2 IRin; 3 Rout=8'h20, Rin=8'h04, Done; cycle 4 back in T0.
4. sub R1,R2 (IR=011_001_010) -> E1 Rout=8'h02+Ain; E2 Rout=8'h04+Gin+alu_op=01; E3 Gout+Rin=8'h02+Done; 6 cycles total.
5. mvi R7 (IR=001_111_000) -> E1 Rout=8'h80+ADDRin; E2 incr_pc; E3 DINout+Rin=8'h80, incr_pc=0, Done.
6. st R3,R4 (IR=101_011_100) -> E1 Rout=8'h10+ADDRin; E2 Rout=8'h08+DOUTin+W_D+Done; 5 cycles. mvnz (IR=110_000_001) with Gnz=0 -> Rin=0, Done; with Gnz=1 -> Rout=8'h02, Rin=8'h01, Done.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the processor control path: opcodes, ALU codes,
// FSM state encoding and default register-file geometry.
package proc_pkg;

    localparam int unsigned NREG_DEF   = 8;
    localparam int unsigned PC_IDX_DEF = 7;
    localparam int unsigned IR_W_DEF   = 9;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    typedef enum logic [2:0] {
        S_T0,
        S_T1,
        S_T2,
        S_E1,
        S_E2,
        S_E3
    } state_t;

endpackage

// File: rtl/proc_control_dec3to8.sv
// 3-bit register index to 8-bit one-hot select, used for the X and Y fields.
module dec3to8 (
    input  logic [2:0] w,
    output logic [7:0] y
);

    always_comb begin
        y    = '0;
        y[w] = 1'b1;
    end

endmodule

// File: rtl/proc_control.sv
// Multi-cycle fetch/execute sequencer for the 8-register processor; every
// strobe is decoded combinationally from the current step and the IR fields.
module proc_control
    import proc_pkg::*;
#(
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned PC_IDX = PC_IDX_DEF,
    parameter int unsigned IR_W   = IR_W_DEF
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            Run,
    input  logic [IR_W-1:0] IR,
    input  logic            Gnz,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            Gout,
    output logic            DINout,
    output logic            IRin,
    output logic            Ain,
    output logic            Gin,
    output logic [1:0]      alu_op,
    output logic            ADDRin,
    output logic            DOUTin,
    output logic            W_D,
    output logic            incr_pc,
    output logic            Done
);

    state_t     state, state_nx;
    logic [2:0] op;
    logic [7:0] xsel, ysel;

    assign op = IR[IR_W-1 -: 3];

    dec3to8 u_decx (.w(IR[IR_W-4 -: 3]), .y(xsel));
    dec3to8 u_decy (.w(IR[2:0]),         .y(ysel));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= S_T0;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        Rin      = '0;
        Rout     = '0;
        Gout     = 1'b0;
        DINout   = 1'b0;
        IRin     = 1'b0;
        Ain      = 1'b0;
        Gin      = 1'b0;
        alu_op   = ALU_ADD;
        ADDRin   = 1'b0;
        DOUTin   = 1'b0;
        W_D      = 1'b0;
        incr_pc  = 1'b0;
        Done     = 1'b0;
        // Outputs are gated by Resetn as well as state so T0+Run cannot leak a fetch during reset.
        if (Resetn) begin
            case (state)
                S_T0: if (Run) begin
                    Rout[PC_IDX] = 1'b1;
                    ADDRin       = 1'b1;
                    state_nx     = S_T1;
                end
                S_T1: begin
                    incr_pc  = 1'b1;
                    state_nx = S_T2;
                end
                S_T2: begin
                    IRin     = 1'b1;
                    state_nx = S_E1;
                end
                S_E1: begin
                    state_nx = S_E2;
                    case (op)
                        OP_MV: begin
                            Rout = ysel; Rin = xsel; Done = 1'b1; state_nx = S_T0;
                        end
                        OP_MVI: begin
                            Rout[PC_IDX] = 1'b1; ADDRin = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_AND: begin
                            Rout = xsel; Ain = 1'b1;
                        end
                        OP_LD, OP_ST: begin
                            Rout = ysel; ADDRin = 1'b1;
                        end
                        default: begin
                            if (Gnz) begin
                                Rout = ysel; Rin = xsel;
                            end
                            Done = 1'b1; state_nx = S_T0;
                        end
                    endcase
                end
                S_E2: begin
                    state_nx = S_E3;
                    case (op)
                        OP_MVI: incr_pc = 1'b1;
                        OP_ADD: begin Rout = ysel; Gin = 1'b1; alu_op = ALU_ADD; end
                        OP_SUB: begin Rout = ysel; Gin = 1'b1; alu_op = ALU_SUB; end
                        OP_AND: begin Rout = ysel; Gin = 1'b1; alu_op = ALU_AND; end
                        OP_LD:  ;
                        OP_ST: begin
                            Rout = xsel; DOUTin = 1'b1; W_D = 1'b1; Done = 1'b1;
                            state_nx = S_T0;
                        end
                        default: state_nx = S_T0;
                    endcase
                end
                S_E3: begin
                    state_nx = S_T0;
                    case (op)
                        OP_MVI, OP_LD: begin
                            DINout = 1'b1; Rin = xsel; Done = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_AND: begin
                            Gout = 1'b1; Rin = xsel; Done = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: state_nx = S_T0;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_control.sv
// Randomized bench for proc_control: a per-opcode step table predicts every
// cycle's full strobe vector, including fetch, idle T0 and mid-instruction reset.
module tb_proc_control;

    typedef logic [27:0] vec_t;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       Run;
    logic [8:0] IR;
    logic       Gnz;
    logic [7:0] Rin, Rout;
    logic       Gout, DINout, IRin, Ain, Gin, ADDRin, DOUTin, W_D, incr_pc, Done;
    logic [1:0] alu_op;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    vec_t        expq[$];

    proc_control #(.NREG(8), .PC_IDX(7), .IR_W(9)) dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR), .Gnz(Gnz),
        .Rin(Rin), .Rout(Rout), .Gout(Gout), .DINout(DINout), .IRin(IRin),
        .Ain(Ain), .Gin(Gin), .alu_op(alu_op), .ADDRin(ADDRin), .DOUTin(DOUTin),
        .W_D(W_D), .incr_pc(incr_pc), .Done(Done)
    );

    always #5 Clock = ~Clock;

    function automatic vec_t pk(input logic [7:0] rin, input logic [7:0] rout,
                                input logic gout, input logic dinout, input logic irin,
                                input logic ain, input logic gin, input logic [1:0] alu,
                                input logic addrin, input logic doutin, input logic wd,
                                input logic incr, input logic done);
        return {rin, rout, gout, dinout, irin, ain, gin, alu, addrin, doutin, wd, incr, done};
    endfunction

    function automatic vec_t observed();
        return {Rin, Rout, Gout, DINout, IRin, Ain, Gin, alu_op, ADDRin, DOUTin, W_D, incr_pc, Done};
    endfunction

    task automatic check_eq(input string tag, input vec_t obs, input vec_t exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    // Expected strobe sequence for one whole instruction, fetch included.
    task automatic build_model(input logic [8:0] ir, input logic gnz);
        logic [2:0] op = ir[8:6];
        logic [7:0] xo = 8'd1 << ir[5:3];
        logic [7:0] yo = 8'd1 << ir[2:0];
        logic [1:0] alu;
        expq.delete();
        expq.push_back(pk(0, 8'h80, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        expq.push_back(pk(0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        expq.push_back(pk(0, 0,     0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        case (op)
            3'd0: expq.push_back(pk(xo, yo, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            3'd1: begin
                expq.push_back(pk(0,  8'h80, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
                expq.push_back(pk(0,  0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
                expq.push_back(pk(xo, 0,     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            end
            3'd4: begin
                expq.push_back(pk(0,  yo, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
                expq.push_back(pk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                expq.push_back(pk(xo, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            end
            3'd5: begin
                expq.push_back(pk(0, yo, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
                expq.push_back(pk(0, xo, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
            end
            3'd6: expq.push_back(gnz ? pk(xo, yo, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)
                                     : pk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            default: begin
                alu = (op == 3'd2) ? 2'b00 : (op == 3'd3) ? 2'b01 : 2'b10;
                expq.push_back(pk(0,  xo, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0));
                expq.push_back(pk(0,  yo, 0, 0, 0, 0, 1, alu, 0, 0, 0, 0, 0));
                expq.push_back(pk(xo, 0,  1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1));
            end
        endcase
    endtask

    // Called in the window just after a falling edge; returns in the same phase.
    task automatic run_instr(input logic [8:0] ir, input logic gnz, input bit drop_run,
                             input int unsigned stop_at);
        string tag;
        build_model(ir, gnz);
        tag = $sformatf("op%0d_ir%h", ir[8:6], ir);
        for (int unsigned i = 0; i < expq.size() && i < stop_at; i++) begin
            Run = (i == 0) ? 1'b1 : (drop_run ? 1'($urandom_range(0, 1)) : 1'b1);
            IR  = ir;
            Gnz = gnz;
            #1;
            check_eq($sformatf("%s_c%0d", tag, i), observed(), expq[i]);
            @(negedge Clock);
        end
    endtask

    task automatic idle_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            Run = 1'b0;
            IR  = 9'($urandom);
            Gnz = 1'($urandom);
            #1;
            check_eq("idle_t0", observed(), '0);
            @(negedge Clock);
        end
    endtask

    task automatic reset_now();
        Resetn = 1'b0;
        Run    = 1'b1;
        #1;
        check_eq("reset_immediate", observed(), '0);
        @(posedge Clock);
        #1;
        check_eq("reset_held", observed(), '0);
        @(negedge Clock);
        Resetn = 1'b1;
        #1;
        check_eq("reset_release_fetch", observed(), pk(0, 8'h80, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    endtask

    initial begin
        Resetn = 1'b0;
        Run    = 1'b1;
        IR     = '0;
        Gnz    = 1'b0;
        #2;
        check_eq("reset_start", observed(), '0);
        @(negedge Clock);
        Resetn = 1'b1;

        idle_cycles(5);
        run_instr(9'b000_010_101, 1'b0, 1'b0, 99);
        idle_cycles(1);
        run_instr(9'b011_001_010, 1'b0, 1'b0, 99);
        run_instr(9'b001_111_000, 1'b0, 1'b0, 99);
        run_instr(9'b101_011_100, 1'b0, 1'b0, 99);
        run_instr(9'b110_000_001, 1'b0, 1'b0, 99);
        run_instr(9'b110_000_001, 1'b1, 1'b0, 99);
        run_instr(9'b100_110_111, 1'b1, 1'b1, 99);
        run_instr(9'b111_111_111, 1'b0, 1'b1, 99);

        // Reset landing in add E2 (fetch 3 cycles + E1 done).
        run_instr(9'b010_011_100, 1'b0, 1'b0, 4);
        reset_now();

        for (int n = 0; n < 300; n++) begin
            logic [8:0] ir  = 9'($urandom);
            logic       gnz = 1'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                run_instr(ir, gnz, 1'b1, $urandom_range(0, 5));
                reset_now();
            end else begin
                run_instr(ir, gnz, $urandom_range(0, 1) == 1, 99);
                if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog t=%0t observed=timeout expected=finish", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
